// File: rtl/ml_regressor_seq_ctrl.sv
// AXI4-Lite master that runs one ml_regressor inference per request: feature writes, start, STATUS poll, RESULT read.
// Optional poll timeout is enabled with `define ML_SEQ_POLL_TIMEOUT_EN (limit set by MAX_POLL).
module ml_regressor_seq_ctrl #(
    parameter int          NUM_FEAT  = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_POLL  = 1024
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [NUM_FEAT*32-1:0] req_feat,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [31:0]            rsp_data,
    output logic                   rsp_err,
    output logic [31:0]            M_AXI_AWADDR,
    output logic [2:0]             M_AXI_AWPROT,
    output logic                   M_AXI_AWVALID,
    input  logic                   M_AXI_AWREADY,
    output logic [31:0]            M_AXI_WDATA,
    output logic [3:0]             M_AXI_WSTRB,
    output logic                   M_AXI_WVALID,
    input  logic                   M_AXI_WREADY,
    input  logic [1:0]             M_AXI_BRESP,
    input  logic                   M_AXI_BVALID,
    output logic                   M_AXI_BREADY,
    output logic [31:0]            M_AXI_ARADDR,
    output logic [2:0]             M_AXI_ARPROT,
    output logic                   M_AXI_ARVALID,
    input  logic                   M_AXI_ARREADY,
    input  logic [31:0]            M_AXI_RDATA,
    input  logic [1:0]             M_AXI_RRESP,
    input  logic                   M_AXI_RVALID,
    output logic                   M_AXI_RREADY
);

    localparam int          IDX_W    = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
    localparam logic [31:0] OFS_CTRL = 32'h0;
    localparam logic [31:0] OFS_STAT = 32'h4;
    localparam logic [31:0] OFS_DATA = 32'h8;
    localparam logic [31:0] OFS_RES  = 32'hC;

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_WB, S_RD_STAT, S_RS, S_RD_RES, S_RR, S_RESP
    } state_t;

    state_t                  state;
    logic [NUM_FEAT*32-1:0]  feat_q;
    logic [IDX_W-1:0]        feat_idx;
    logic                    is_start;
    logic                    aw_done;
    logic                    w_done;
`ifdef ML_SEQ_POLL_TIMEOUT_EN
    localparam int POLL_W = $clog2(MAX_POLL + 1);
    logic [POLL_W-1:0]       poll_cnt;
`endif

    logic aw_hs, w_hs, aw_fin, w_fin;
    assign aw_hs  = M_AXI_AWVALID & M_AXI_AWREADY;
    assign w_hs   = M_AXI_WVALID & M_AXI_WREADY;
    assign aw_fin = aw_done | aw_hs;
    assign w_fin  = w_done | w_hs;

    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;
    assign M_AXI_WSTRB  = 4'hF;

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // branch sees the pre-edge values; feat_q is not reset because it is always loaded before use.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state         <= S_IDLE;
            req_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_err       <= 1'b0;
            rsp_data      <= '0;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            feat_idx      <= '0;
            is_start      <= 1'b0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
`ifdef ML_SEQ_POLL_TIMEOUT_EN
            poll_cnt      <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready     <= 1'b0;
                        feat_q        <= req_feat;
                        feat_idx      <= '0;
                        is_start      <= 1'b0;
                        M_AXI_AWADDR  <= BASE_ADDR + OFS_DATA;
                        M_AXI_WDATA   <= req_feat[31:0];
                        M_AXI_AWVALID <= 1'b1;
                        M_AXI_WVALID  <= 1'b1;
                        aw_done       <= 1'b0;
                        w_done        <= 1'b0;
                        state         <= S_WR;
                    end
                end
                S_WR: begin
                    // AW and W complete independently; B is only awaited once both have.
                    if (aw_hs) begin
                        M_AXI_AWVALID <= 1'b0;
                        aw_done       <= 1'b1;
                    end
                    if (w_hs) begin
                        M_AXI_WVALID <= 1'b0;
                        w_done       <= 1'b1;
                    end
                    if (aw_fin && w_fin) begin
                        M_AXI_BREADY <= 1'b1;
                        state        <= S_WB;
                    end
                end
                S_WB: begin
                    if (M_AXI_BVALID) begin
                        M_AXI_BREADY <= 1'b0;
                        if (M_AXI_BRESP != 2'b00) begin
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                            rsp_valid <= 1'b1;
                            state     <= S_RESP;
                        end else if (is_start) begin
                            M_AXI_ARADDR  <= BASE_ADDR + OFS_STAT;
                            M_AXI_ARVALID <= 1'b1;
`ifdef ML_SEQ_POLL_TIMEOUT_EN
                            poll_cnt      <= '0;
`endif
                            state         <= S_RD_STAT;
                        end else begin
                            if (feat_idx == IDX_W'(NUM_FEAT - 1)) begin
                                is_start     <= 1'b1;
                                M_AXI_AWADDR <= BASE_ADDR + OFS_CTRL;
                                M_AXI_WDATA  <= 32'h1;
                            end else begin
                                feat_idx     <= feat_idx + 1'b1;
                                M_AXI_AWADDR <= BASE_ADDR + OFS_DATA;
                                M_AXI_WDATA  <= feat_q[32*(int'(feat_idx) + 1) +: 32];
                            end
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                            aw_done       <= 1'b0;
                            w_done        <= 1'b0;
                            state         <= S_WR;
                        end
                    end
                end
                S_RD_STAT: begin
                    if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        state         <= S_RS;
                    end
                end
                S_RS: begin
                    if (M_AXI_RVALID) begin
                        M_AXI_RREADY <= 1'b0;
                        if (M_AXI_RRESP != 2'b00) begin
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                            rsp_valid <= 1'b1;
                            state     <= S_RESP;
                        end else if (M_AXI_RDATA[0]) begin
                            M_AXI_ARADDR  <= BASE_ADDR + OFS_RES;
                            M_AXI_ARVALID <= 1'b1;
                            state         <= S_RD_RES;
`ifdef ML_SEQ_POLL_TIMEOUT_EN
                        end else if (poll_cnt == POLL_W'(MAX_POLL - 1)) begin
                            poll_cnt  <= poll_cnt + 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= 32'hDEAD_0000;
                            rsp_valid <= 1'b1;
                            state     <= S_RESP;
`endif
                        end else begin
`ifdef ML_SEQ_POLL_TIMEOUT_EN
                            poll_cnt      <= poll_cnt + 1'b1;
`endif
                            M_AXI_ARVALID <= 1'b1;
                            state         <= S_RD_STAT;
                        end
                    end
                end
                S_RD_RES: begin
                    if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        state         <= S_RR;
                    end
                end
                S_RR: begin
                    if (M_AXI_RVALID) begin
                        M_AXI_RREADY <= 1'b0;
                        rsp_data     <= M_AXI_RDATA;
                        rsp_err      <= (M_AXI_RRESP != 2'b00);
                        rsp_valid    <= 1'b1;
                        state        <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ml_regressor_seq_ctrl.sv
// Directed bench for ml_regressor_seq_ctrl with a behavioural AXI4-Lite regressor slave and protocol monitor.
module tb_ml_regressor_seq_ctrl;

    logic         ACLK = 1'b0;
    logic         ARESET = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [127:0] req_feat = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [31:0]  rsp_data;
    logic         rsp_err;
    logic [31:0]  AWADDR, WDATA, ARADDR;
    logic [2:0]   AWPROT, ARPROT;
    logic [3:0]   WSTRB;
    logic         AWVALID, WVALID, BREADY, ARVALID, RREADY;
    logic         AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0, ARREADY = 1'b0, RVALID = 1'b0;
    logic [1:0]   BRESP = 2'b00, RRESP = 2'b00;
    logic [31:0]  RDATA = '0;

    ml_regressor_seq_ctrl #(.NUM_FEAT(4), .BASE_ADDR(32'h0), .MAX_POLL(8)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_feat(req_feat),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
        .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
        .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
        .M_AXI_ARADDR(ARADDR), .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
        .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    int total = 0;
    int bad = 0;

    // Slave knobs, set only by the stimulus process.
    int          aw_delay = 0, w_delay = 0, err_write = -1, done_after = 3, stat_base = 0;
    logic [31:0] result_val = 32'hA;

    // Slave bookkeeping, written only by the slave process.
    int          wr_cnt = 0, aw_cnt = 0, b_cnt = 0, stat_reads = 0, res_reads = 0;
    int          aw_wait = 0, w_wait = 0;
    bit          aw_got = 0, w_got = 0;
    logic [31:0] got_awaddr = '0, got_wdata = '0;
    logic [31:0] wr_addr_log [256];
    logic [31:0] wr_data_log [256];

    always @(posedge ACLK) begin
        if (ARESET) begin
            AWREADY <= 0; WREADY <= 0; BVALID <= 0; BRESP <= 0;
            ARREADY <= 0; RVALID <= 0; RRESP <= 0; RDATA <= 0;
            aw_got <= 0; w_got <= 0; aw_wait <= 0; w_wait <= 0;
        end else begin
            if (AWVALID && AWREADY) begin
                AWREADY <= 0; aw_got <= 1; got_awaddr <= AWADDR; aw_cnt <= aw_cnt + 1; aw_wait <= 0;
            end else if (AWVALID && !aw_got) begin
                if (aw_wait >= aw_delay) AWREADY <= 1; else aw_wait <= aw_wait + 1;
            end
            if (WVALID && WREADY) begin
                WREADY <= 0; w_got <= 1; got_wdata <= WDATA; w_wait <= 0;
            end else if (WVALID && !w_got) begin
                if (w_wait >= w_delay) WREADY <= 1; else w_wait <= w_wait + 1;
            end
            if (aw_got && w_got && !BVALID) begin
                BVALID <= 1;
                BRESP  <= (wr_cnt == err_write) ? 2'b10 : 2'b00;
                wr_addr_log[wr_cnt % 256] <= got_awaddr;
                wr_data_log[wr_cnt % 256] <= got_wdata;
                wr_cnt <= wr_cnt + 1;
                aw_got <= 0; w_got <= 0;
            end
            if (BVALID && BREADY) begin
                BVALID <= 0; b_cnt <= b_cnt + 1;
            end
            if (ARVALID && ARREADY) begin
                ARREADY <= 0; RVALID <= 1; RRESP <= 2'b00;
                if (ARADDR == 32'h4) begin
                    // Not-done status has every bit except done set, so only bit0 may matter.
                    RDATA <= ((stat_reads - stat_base) >= done_after) ? 32'h1 : 32'hFFFF_FFFE;
                    stat_reads <= stat_reads + 1;
                end else begin
                    RDATA <= result_val; res_reads <= res_reads + 1;
                end
            end else if (ARVALID && !RVALID) begin
                ARREADY <= 1;
            end
            if (RVALID && RREADY) RVALID <= 0;
        end
    end

    // Protocol monitor: VALID hold/stability, no read/write overlap, req_ready only when idle.
    int          viol = 0;
    logic        last_rst = 1'b1, last_awv = 0, last_awr = 0, last_wv = 0, last_wr = 0, last_arv = 0, last_arr = 0;
    logic [31:0] last_awaddr = '0, last_wdata = '0, last_araddr = '0;

    always @(posedge ACLK) begin
        if (!last_rst && !ARESET) begin
            if (last_awv && !last_awr && (!AWVALID || AWADDR != last_awaddr)) viol = viol + 1;
            if (last_wv && !last_wr && (!WVALID || WDATA != last_wdata)) viol = viol + 1;
            if (last_arv && !last_arr && (!ARVALID || ARADDR != last_araddr)) viol = viol + 1;
            if ((AWVALID || WVALID || BREADY) && (ARVALID || RREADY)) viol = viol + 1;
            if (req_ready && (AWVALID || WVALID || BREADY || ARVALID || RREADY || rsp_valid)) viol = viol + 1;
            if (ARVALID && ARADDR != 32'h4 && ARADDR != 32'hC) viol = viol + 1;
            if (AWPROT != 3'b000 || ARPROT != 3'b000 || WSTRB != 4'hF) viol = viol + 1;
        end
        last_rst <= ARESET;
        last_awv <= AWVALID; last_awr <= AWREADY; last_awaddr <= AWADDR;
        last_wv  <= WVALID;  last_wr  <= WREADY;  last_wdata  <= WDATA;
        last_arv <= ARVALID; last_arr <= ARREADY; last_araddr <= ARADDR;
    end

    int wb, ab, bb, sb, rb;

    task automatic snap();
        wb = wr_cnt; ab = aw_cnt; bb = b_cnt; sb = stat_reads; rb = res_reads;
        stat_base = stat_reads;
    endtask

    // Called at a negedge; returns at a negedge with rsp_valid high, or ok=0 after the budget.
    task automatic run_txn(input logic [127:0] f, output bit ok);
        int n;
        req_feat = f; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 200) begin @(negedge ACLK); n++; end
        @(posedge ACLK); #1 req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 2000) begin @(negedge ACLK); n++; end
        ok = rsp_valid;
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(negedge ACLK);
        rsp_ready = 1'b0;
    endtask

    function automatic logic [31:0] exp_wr_addr(input int i);
        return (i < 4) ? 32'h8 : 32'h0;
    endfunction

    function automatic logic [31:0] exp_wr_data(input logic [127:0] f, input int i);
        return (i < 4) ? f[32*i +: 32] : 32'h1;
    endfunction

    task automatic test_reset();
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        total++;
        if ({AWVALID, WVALID, BREADY, ARVALID, RREADY, req_ready, rsp_valid, rsp_err} !== 8'h00) begin
            bad++; $display("FAIL reset_ctrl: got %b want 00000000",
                {AWVALID, WVALID, BREADY, ARVALID, RREADY, req_ready, rsp_valid, rsp_err});
        end
        total++;
        if ({rsp_data, AWADDR, WDATA, ARADDR} !== 128'h0) begin
            bad++; $display("FAIL reset_data: rsp_data=%h aw=%h w=%h ar=%h want all 0", rsp_data, AWADDR, WDATA, ARADDR);
        end
        ARESET = 1'b0;
        @(negedge ACLK);
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_idle_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_basic();
        logic [127:0] f;
        bit ok;
        f = {32'd4, 32'd3, 32'd2, 32'd1};
        snap(); done_after = 3; result_val = 32'h0000_000A;
        run_txn(f, ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_timeout: got rsp_valid=%b want 1", rsp_valid); end
        total++; if (rsp_data !== 32'hA) begin bad++; $display("FAIL basic_data: got %h want 0000000a", rsp_data); end
        total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL basic_err: got %b want 0", rsp_err); end
        total++; if (wr_cnt - wb != 5) begin bad++; $display("FAIL basic_writes: got %0d want 5", wr_cnt - wb); end
        total++; if (b_cnt - bb != 5) begin bad++; $display("FAIL basic_bresp: got %0d want 5", b_cnt - bb); end
        total++; if (stat_reads - sb != 4) begin bad++; $display("FAIL basic_polls: got %0d want 4", stat_reads - sb); end
        total++; if (res_reads - rb != 1) begin bad++; $display("FAIL basic_result_reads: got %0d want 1", res_reads - rb); end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (wr_addr_log[(wb + i) % 256] !== exp_wr_addr(i) || wr_data_log[(wb + i) % 256] !== exp_wr_data(f, i)) begin
                bad++; $display("FAIL basic_write%0d: got %h<=%h want %h<=%h", i, wr_addr_log[(wb + i) % 256],
                    wr_data_log[(wb + i) % 256], exp_wr_addr(i), exp_wr_data(f, i));
            end
        end
        take_rsp();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL basic_rsp_clear: got %b want 0", rsp_valid); end
        total++; if (viol != 0) begin bad++; $display("FAIL basic_protocol: got %0d violations want 0", viol); end
    endtask

    task automatic test_skew();
        logic [127:0] f;
        bit ok;
        f = {32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
        for (int s = 0; s < 2; s++) begin
            aw_delay = (s == 0) ? 0 : 3;
            w_delay  = (s == 0) ? 3 : 0;
            snap(); done_after = 3; result_val = 32'h0000_000A;
            run_txn(f, ok);
            total++; if (!ok) begin bad++; $display("FAIL skew%0d_timeout: got rsp_valid=%b want 1", s, rsp_valid); end
            total++;
            if (rsp_data !== 32'hA || rsp_err !== 1'b0) begin
                bad++; $display("FAIL skew%0d_result: got %h err %b want 0000000a err 0", s, rsp_data, rsp_err);
            end
            total++;
            if (wr_cnt - wb != 5 || b_cnt - bb != 5 || aw_cnt - ab != 5) begin
                bad++; $display("FAIL skew%0d_counts: got w=%0d b=%0d aw=%0d want 5 5 5", s, wr_cnt - wb, b_cnt - bb, aw_cnt - ab);
            end
            for (int i = 0; i < 5; i++) begin
                total++;
                if (wr_addr_log[(wb + i) % 256] !== exp_wr_addr(i) || wr_data_log[(wb + i) % 256] !== exp_wr_data(f, i)) begin
                    bad++; $display("FAIL skew%0d_write%0d: got %h<=%h want %h<=%h", s, i, wr_addr_log[(wb + i) % 256],
                        wr_data_log[(wb + i) % 256], exp_wr_addr(i), exp_wr_data(f, i));
                end
            end
            take_rsp();
        end
        aw_delay = 0; w_delay = 0;
        total++; if (viol != 0) begin bad++; $display("FAIL skew_protocol: got %0d violations want 0", viol); end
    endtask

    task automatic test_bresp_err();
        bit ok;
        snap(); err_write = wb + 1; done_after = 3;
        run_txn({32'd8, 32'd7, 32'd6, 32'd5}, ok);
        total++; if (!ok) begin bad++; $display("FAIL slverr_timeout: got rsp_valid=%b want 1", rsp_valid); end
        total++;
        if (rsp_err !== 1'b1 || rsp_data !== 32'h0) begin
            bad++; $display("FAIL slverr_rsp: got %h err %b want 00000000 err 1", rsp_data, rsp_err);
        end
        repeat (5) @(negedge ACLK);
        total++;
        if (aw_cnt - ab != 2 || wr_cnt - wb != 2 || stat_reads - sb != 0 || res_reads - rb != 0) begin
            bad++; $display("FAIL slverr_abort: got aw=%0d w=%0d stat=%0d res=%0d want 2 2 0 0",
                aw_cnt - ab, wr_cnt - wb, stat_reads - sb, res_reads - rb);
        end
        take_rsp();
        err_write = -1;
        total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL slverr_err_clear: got %b want 0", rsp_err); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] f2;
        bit ok, stable;
        int n;
        f2 = {32'hD4, 32'hC3, 32'hB2, 32'hA1};
        snap(); done_after = 1; result_val = 32'h55;
        run_txn({32'd1, 32'd1, 32'd1, 32'd1}, ok);
        total++; if (!ok) begin bad++; $display("FAIL hold_timeout: got rsp_valid=%b want 1", rsp_valid); end
        req_feat = f2; req_valid = 1'b1;
        stable = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge ACLK);
            if (rsp_valid !== 1'b1 || rsp_data !== 32'h55 || req_ready !== 1'b0) stable = 0;
        end
        total++;
        if (!stable) begin bad++; $display("FAIL hold_stable: got valid=%b data=%h ready=%b want 1 00000055 0", rsp_valid, rsp_data, req_ready); end
        result_val = 32'h66;
        wb = wr_cnt;
        take_rsp();
        total++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++; $display("FAIL hold_release: got valid=%b ready=%b want 0 1", rsp_valid, req_ready);
        end
        @(posedge ACLK); #1 req_valid = 1'b0;
        @(negedge ACLK);
        total++;
        if (req_ready !== 1'b0 || AWVALID !== 1'b1) begin
            bad++; $display("FAIL second_accept: got ready=%b awvalid=%b want 0 1", req_ready, AWVALID);
        end
        n = 0;
        while (!rsp_valid && n < 2000) begin @(negedge ACLK); n++; end
        total++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h66 || rsp_err !== 1'b0) begin
            bad++; $display("FAIL second_result: got valid=%b data=%h err=%b want 1 00000066 0", rsp_valid, rsp_data, rsp_err);
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (wr_data_log[(wb + i) % 256] !== exp_wr_data(f2, i)) begin
                bad++; $display("FAIL second_write%0d: got %h want %h", i, wr_data_log[(wb + i) % 256], exp_wr_data(f2, i));
            end
        end
        take_rsp();
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n;
        snap(); done_after = 1 << 20;
        req_feat = {32'd9, 32'd9, 32'd9, 32'd9}; req_valid = 1'b1;
        @(posedge ACLK); #1 req_valid = 1'b0;
        n = 0;
        while (!(RREADY && stat_reads - sb >= 2) && n < 500) begin @(negedge ACLK); n++; end
        total++; if (RREADY !== 1'b1) begin bad++; $display("FAIL midreset_reach_rs: got rready=%b want 1", RREADY); end
        ARESET = 1'b1;
        @(negedge ACLK);
        total++;
        if ({AWVALID, WVALID, BREADY, ARVALID, RREADY, req_ready, rsp_valid, rsp_err} !== 8'h00 || rsp_data !== 32'h0) begin
            bad++; $display("FAIL midreset_outputs: got %b data %h want 00000000 data 0",
                {AWVALID, WVALID, BREADY, ARVALID, RREADY, req_ready, rsp_valid, rsp_err}, rsp_data);
        end
        ARESET = 1'b0;
        @(negedge ACLK);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL midreset_idle: got req_ready=%b want 1", req_ready); end
        snap(); done_after = 2; result_val = 32'h77;
        run_txn({32'd40, 32'd30, 32'd20, 32'd10}, ok);
        total++;
        if (!ok || rsp_data !== 32'h77 || rsp_err !== 1'b0) begin
            bad++; $display("FAIL midreset_recover: got valid=%b data=%h err=%b want 1 00000077 0", rsp_valid, rsp_data, rsp_err);
        end
        total++;
        if (wr_cnt - wb != 5 || stat_reads - sb != 3) begin
            bad++; $display("FAIL midreset_counts: got w=%0d stat=%0d want 5 3", wr_cnt - wb, stat_reads - sb);
        end
        take_rsp();
    endtask

    task automatic test_poll_limit();
        bit ok;
        snap();
`ifdef ML_SEQ_POLL_TIMEOUT_EN
        done_after = 1 << 20; result_val = 32'h99;
        run_txn({32'd4, 32'd3, 32'd2, 32'd1}, ok);
        total++;
        if (!ok || rsp_err !== 1'b1 || rsp_data !== 32'hDEAD_0000) begin
            bad++; $display("FAIL poll_timeout_rsp: got valid=%b data=%h err=%b want 1 dead0000 1", rsp_valid, rsp_data, rsp_err);
        end
        total++;
        if (stat_reads - sb != 8 || res_reads - rb != 0) begin
            bad++; $display("FAIL poll_timeout_reads: got stat=%0d res=%0d want 8 0", stat_reads - sb, res_reads - rb);
        end
`else
        done_after = 12; result_val = 32'h99;
        run_txn({32'd4, 32'd3, 32'd2, 32'd1}, ok);
        total++;
        if (!ok || rsp_err !== 1'b0 || rsp_data !== 32'h99) begin
            bad++; $display("FAIL poll_long_rsp: got valid=%b data=%h err=%b want 1 00000099 0", rsp_valid, rsp_data, rsp_err);
        end
        total++;
        if (stat_reads - sb != 13 || res_reads - rb != 1) begin
            bad++; $display("FAIL poll_long_reads: got stat=%0d res=%0d want 13 1", stat_reads - sb, res_reads - rb);
        end
`endif
        take_rsp();
        total++; if (viol != 0) begin bad++; $display("FAIL final_protocol: got %0d violations want 0", viol); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_skew();
        test_bresp_err();
        test_back_to_back();
        test_reset_mid();
        test_poll_limit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
